pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Fetch sequencer that owns the next-address input of the program-counter register (`reg_pc`) and the instruction-memory request port.
- Each cycle it drives `pc_next`, which `reg_pc` loads unconditionally, and reads back `pc_cur`.
- It issues word fetches with a req/ack handshake and holds the fetched instruction for decode under a valid/ready handshake.
- It applies branch/jump redirects, and traps on misaligned redirect targets and on fetch timeouts.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (32): address/PC width.
- TRAP_VECTOR, 32'h0000_0100: PC loaded on any trap; low two bits must be 0.
- TIMEOUT, 16: max cycles in REQ without ack before a fetch-timeout trap; range 2..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_cur  in  DATA_WIDTH  current PC, from the `reg_pc` output.
- pc_next  out  DATA_WIDTH  next PC, to the `reg_pc` input; combinational.
- imem_req  out  1  fetch request, level.
- imem_addr  out  DATA_WIDTH  fetch address; always equals pc_cur.
- imem_ack  in  1  fetch data valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  held instruction.
- instr_pc  out  DATA_WIDTH  PC of the held instruction.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  decode accepts instr.
- redirect  in  1  branch/jump taken, single-cycle pulse.
- redirect_addr  in  DATA_WIDTH  redirect target.
- trap  out  1  one-cycle trap pulse.
- trap_cause  out  2  01 = misaligned redirect, 10 = fetch timeout, 00 = none.
- trap_addr  out  DATA_WIDTH  offending target, or the PC that timed out.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; instr_valid, imem_req and trap = 0; trap_cause = 00.
  - instr, instr_pc, trap_addr and timeout counter = 0.
  - pc_next = 0 while reset is high, consistent with the 0 reset value of `reg_pc`.
  - Reset asserted mid-fetch or mid-hold abandons everything; no trap is raised.
- States:
  - IDLE: one cycle after reset deassertion. pc_next = pc_cur. Go to REQ.
  - REQ: imem_req = 1. Counter increments every cycle in REQ and clears on leaving REQ.
    - On imem_ack: register instr <= imem_rdata and instr_pc <= pc_cur; pc_next = pc_cur + 4; go to HOLD.
    - Without ack: pc_next = pc_cur; stay in REQ.
  - HOLD: instr_valid = 1 and imem_req = 0; pc_next = pc_cur.
    - instr_ready = 1: transfer completes; go to REQ next cycle.
    - instr_ready = 0: stay in HOLD with instr and instr_pc stable.
- Fetch throughput: minimum 2 cycles per instruction (REQ with ack, then HOLD with ready).
- Redirect (any state except reset; highest priority):
  - Go to REQ; instr_valid = 0 next cycle; counter cleared.
  - Aligned target (redirect_addr[1:0] == 00): pc_next = redirect_addr.
  - Misaligned target: pc_next = TRAP_VECTOR; registered one-cycle trap with trap_cause = 01 and trap_addr = redirect_addr.
  - Redirect together with imem_ack in REQ: the fetched word is discarded and instr is not updated.
  - Redirect together with instr_ready in HOLD: the transfer counts as completed, then redirect applies.
  - Abandoning a request by deasserting imem_req is legal; imem holds no outstanding transaction.
- Timeout:
  - In REQ, when the counter reaches TIMEOUT-1 with no ack and no redirect: pc_next = TRAP_VECTOR; one-cycle trap with trap_cause = 10 and trap_addr = pc_cur; stay in REQ with the counter cleared.
  - Ack arriving on that same cycle wins; no trap.
- Priority: reset > redirect > imem_ack > timeout.
- Trap outputs are registered:
  - trap is 1 for exactly one cycle; trap_cause returns to 00 afterwards; trap_addr holds its last value.
- Arithmetic: pc_cur + 4 is modulo 2^DATA_WIDTH; 32'hFFFF_FFFC + 4 wraps to 0 with no trap.
- imem_addr is driven combinationally from pc_cur.

Test Plan:
- Reset, then free-running fetch: imem_ack one cycle after every request, instr_ready = 1 always, rdata = address ^ 32'hA5A5_0000 → instr_pc sequence 0, 4, 8, 0xC; instr matches rdata; one instruction every 2 cycles; trap never asserts.
- Decode backpressure: instr_ready = 0 for 5 cycles in HOLD at instr_pc = 8 → instr_valid stays 1, instr/instr_pc stable, imem_req = 0, pc_cur stays 0xC; fetch resumes the cycle after ready.
- Aligned redirect to 0x200 together with imem_ack in REQ → word discarded; next imem_addr = 0x200; next instr_pc = 0x200; no trap.
- Misaligned redirect to 0x202 while in HOLD → trap = 1 for one cycle, trap_cause = 01, trap_addr = 0x202; imem_addr = 0x100 next.
- Timeout: TIMEOUT = 4, ack withheld at PC 0x10 → trap on the 4th REQ cycle with cause 10 and trap_addr = 0x10; pc_cur = 0x100; ack at cycle 4 of a repeat run → no trap.
- Wrap and reset: redirect to 0xFFFF_FFFC, ack → pc_cur = 0; reset asserted during REQ → pc_next = 0, instr_valid = 0, no trap.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch sequencer driving reg_pc next-address and imem port.
// Handles req/ack fetch, decode hold, redirects and trap generation.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module pc_fetch_ctrl #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR = DATA_WIDTH'('h100),
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pc_cur,
  output logic [DATA_WIDTH-1:0] pc_next,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_addr,
  output logic                  trap,
  output logic [1:0]            trap_cause,
  output logic [DATA_WIDTH-1:0] trap_addr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t state;
  state_t state_d;

  logic [7:0]            cnt;
  logic [7:0]            cnt_d;
  logic                  misalign;
  logic                  timeout_hit;
  logic                  capture;
  logic                  trap_d;
  logic [1:0]            cause_d;
  logic [DATA_WIDTH-1:0] taddr_d;

  assign imem_addr   = pc_cur;
  assign imem_req    = (state == REQ);
  assign instr_valid = (state == HOLD);

  // Event decode: misaligned redirect, fetch timeout, word capture
  always_comb begin
    misalign    = redirect && (redirect_addr[1:0] != 2'b00);
    timeout_hit = (state == REQ) && !redirect && !imem_ack
                  && (cnt == CNT_LAST);
    capture     = (state == REQ) && imem_ack && !redirect;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and next-PC selection; redirect outranks everything
  always_comb begin
    state_d = state;
    pc_next = pc_cur;
    if (reset) begin
      state_d = IDLE;
      pc_next = '0;
    end else if (redirect) begin
      state_d = REQ;
      pc_next = misalign ? TRAP_VECTOR : redirect_addr;
    end else begin
      unique case (state)
        IDLE: begin
          state_d = REQ;
        end
        REQ: begin
          if (imem_ack) begin
            state_d = HOLD;
            pc_next = pc_cur + DATA_WIDTH'(4);
          end else if (timeout_hit) begin
            pc_next = TRAP_VECTOR;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            state_d = REQ;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Counter runs only while waiting in REQ; any exit or trap clears it
  always_comb begin
    cnt_d = '0;
    if ((state == REQ) && !redirect && !imem_ack && !timeout_hit) begin
      cnt_d = cnt + 8'd1;
    end
  end

  // Timeout counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_d;
    end
  end

  // Latch the fetched word and its PC for decode
  always_ff @(posedge clk) begin
    if (reset) begin
      instr    <= '0;
      instr_pc <= '0;
    end else if (capture) begin
      instr    <= imem_rdata;
      instr_pc <= pc_cur;
    end
  end

  // Trap source selection
  always_comb begin
    trap_d  = 1'b0;
    cause_d = 2'b00;
    taddr_d = trap_addr;
    unique case (1'b1)
      misalign: begin
        trap_d  = 1'b1;
        cause_d = 2'b01;
        taddr_d = redirect_addr;
      end
      timeout_hit: begin
        trap_d  = 1'b1;
        cause_d = 2'b10;
        taddr_d = pc_cur;
      end
      default: begin
        trap_d  = 1'b0;
      end
    endcase
  end

  // Registered one-cycle trap pulse; address persists
  always_ff @(posedge clk) begin
    if (reset) begin
      trap       <= 1'b0;
      trap_cause <= 2'b00;
      trap_addr  <= '0;
    end else begin
      trap       <= trap_d;
      trap_cause <= cause_d;
      trap_addr  <= taddr_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: table-driven check of pc_fetch_ctrl with a reg_pc model.
// TIMEOUT is set to 4 so the timeout path is short.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] A = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] trap_addr;

  int total;
  int bad;

  pc_fetch_ctrl #(
    .DATA_WIDTH (32),
    .TRAP_VECTOR(32'h0000_0100),
    .TIMEOUT    (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_cur       (pc_cur),
    .pc_next      (pc_next),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .trap_addr    (trap_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) pc_cur <= pc_next;

  assign imem_rdata = pc_cur ^ A;

  typedef struct {
    logic        rst;
    logic        ack;
    logic        rdy;
    logic        rd;
    logic [31:0] raddr;
    logic [31:0] pnext;
    logic        req;
    logic        vld;
    logic [31:0] ipc;
    logic [31:0] ins;
    logic        trp;
    logic [1:0]  cause;
    logic [31:0] taddr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(
    input logic rst, input logic ack, input logic rdy,
    input logic rd, input logic [31:0] raddr,
    input logic [31:0] pnext, input logic req, input logic vld,
    input logic [31:0] ipc, input logic [31:0] ins,
    input logic trp, input logic [1:0] cause,
    input logic [31:0] taddr);
    vec_t r;
    r.rst = rst; r.ack = ack; r.rdy = rdy;
    r.rd = rd; r.raddr = raddr;
    r.pnext = pnext; r.req = req; r.vld = vld;
    r.ipc = ipc; r.ins = ins;
    r.trp = trp; r.cause = cause; r.taddr = taddr;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ack,
                       input logic rdy, input logic rd,
                       input logic [31:0] raddr);
    reset         = rst;
    imem_ack      = ack;
    instr_ready   = rdy;
    redirect      = rd;
    redirect_addr = raddr;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);

    // t0..t5 free fetch
    vt.push_back(v(0,0,0,0,0, 32'h0,1'b0,0,32'h0,32'h0,0,0,0));
    vt.push_back(v(0,1,0,0,0, 32'h4,1'b1,0,32'h0,32'h0,0,0,0));
    vt.push_back(v(0,0,1,0,0, 32'h4,1'b0,1,32'h0,A|32'h0,0,0,0));
    vt.push_back(v(0,1,0,0,0, 32'h8,1'b1,0,32'h0,A|32'h0,0,0,0));
    vt.push_back(v(0,0,1,0,0, 32'h8,1'b0,1,32'h4,A|32'h4,0,0,0));
    vt.push_back(v(0,1,0,0,0, 32'hC,1'b1,0,32'h4,A|32'h4,0,0,0));
    // t6..t11 backpressure at instr_pc 8
    for (int i = 0; i < 5; i++)
      vt.push_back(v(0,0,0,0,0, 32'hC,1'b0,1,32'h8,A|32'h8,0,0,0));
    vt.push_back(v(0,0,1,0,0, 32'hC,1'b0,1,32'h8,A|32'h8,0,0,0));
    vt.push_back(v(0,1,0,0,0, 32'h10,1'b1,0,32'h8,A|32'h8,0,0,0));
    vt.push_back(v(0,0,1,0,0, 32'h10,1'b0,1,32'hC,A|32'hC,0,0,0));
    // t14..t18 timeout at PC 0x10
    for (int i = 0; i < 3; i++)
      vt.push_back(v(0,0,0,0,0, 32'h10,1'b1,0,32'hC,A|32'hC,0,0,0));
    vt.push_back(v(0,0,0,0,0, 32'h100,1'b1,0,32'hC,A|32'hC,0,0,0));
    vt.push_back(v(0,0,0,0,0, 32'h100,1'b1,0,32'hC,A|32'hC,1,2,32'h10));
    vt.push_back(v(0,1,0,0,0, 32'h104,1'b1,0,32'hC,A|32'hC,0,0,32'h10));
    vt.push_back(v(0,0,1,0,0, 32'h104,1'b0,1,32'h100,A|32'h100,0,0,32'h10));
    // t21..t24 ack on the last counter cycle wins
    for (int i = 0; i < 3; i++)
      vt.push_back(v(0,0,0,0,0, 32'h104,1'b1,0,32'h100,A|32'h100,0,0,32'h10));
    vt.push_back(v(0,1,0,0,0, 32'h108,1'b1,0,32'h100,A|32'h100,0,0,32'h10));
    vt.push_back(v(0,0,1,0,0, 32'h108,1'b0,1,32'h104,A|32'h104,0,0,32'h10));
    // t26 redirect with ack: word dropped
    vt.push_back(v(0,1,0,1,32'h200, 32'h200,1'b1,0,32'h104,A|32'h104,0,0,32'h10));
    vt.push_back(v(0,1,0,0,0, 32'h204,1'b1,0,32'h104,A|32'h104,0,0,32'h10));
    // t28 misaligned redirect in HOLD
    vt.push_back(v(0,0,0,1,32'h202, 32'h100,1'b0,1,32'h200,A|32'h200,0,0,32'h10));
    vt.push_back(v(0,0,0,0,0, 32'h100,1'b1,0,32'h200,A|32'h200,1,1,32'h202));
    // t30 wrap
    vt.push_back(v(0,0,0,1,32'hFFFF_FFFC, 32'hFFFF_FFFC,1'b1,0,32'h200,A|32'h200,0,0,32'h202));
    vt.push_back(v(0,1,0,0,0, 32'h0,1'b1,0,32'h200,A|32'h200,0,0,32'h202));
    vt.push_back(v(0,0,1,0,0, 32'h0,1'b0,1,32'hFFFF_FFFC,32'h5A5A_FFFC,0,0,32'h202));
    // t33..t36 reset mid-REQ
    vt.push_back(v(0,0,0,0,0, 32'h0,1'b1,0,32'hFFFF_FFFC,32'h5A5A_FFFC,0,0,32'h202));
    vt.push_back(v(1,0,0,0,0, 32'h0,1'b1,0,32'hFFFF_FFFC,32'h5A5A_FFFC,0,0,32'h202));
    vt.push_back(v(0,0,0,0,0, 32'h0,1'b0,0,32'h0,32'h0,0,0,0));
    vt.push_back(v(0,1,0,0,0, 32'h4,1'b1,0,32'h0,32'h0,0,0,0));

    // reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_pc_next", -1, pc_next, 32'h0);
    chk("rst_req",     -1, 32'(imem_req), 32'h0);
    chk("rst_valid",   -1, 32'(instr_valid), 32'h0);
    chk("rst_trap",    -1, 32'(trap), 32'h0);
    chk("rst_cause",   -1, 32'(trap_cause), 32'h0);
    chk("rst_instr",   -1, instr, 32'h0);
    chk("rst_ipc",     -1, instr_pc, 32'h0);
    chk("rst_taddr",   -1, trap_addr, 32'h0);

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].rst, vt[i].ack, vt[i].rdy, vt[i].rd, vt[i].raddr);
      #1;
      chk("pc_next",   i, pc_next, vt[i].pnext);
      chk("imem_addr", i, imem_addr, pc_cur);
      chk("imem_req",  i, 32'(imem_req), 32'(vt[i].req));
      chk("valid",     i, 32'(instr_valid), 32'(vt[i].vld));
      chk("instr_pc",  i, instr_pc, vt[i].ipc);
      chk("instr",     i, instr, vt[i].ins);
      chk("trap",      i, 32'(trap), 32'(vt[i].trp));
      chk("cause",     i, 32'(trap_cause), 32'(vt[i].cause));
      chk("trap_addr", i, trap_addr, vt[i].taddr);
    end

    // Free-running stream: 4 transfers in 8 cycles, PCs 0,4,8,C
    begin
      int n;
      logic [31:0] epc;
      n   = 0;
      epc = 32'h0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        drive(1'b0, imem_req, 1'b1, 1'b0, '0);
        #1;
        chk("stream_trap", 100 + c, 32'(trap), 32'h0);
        if (instr_valid) begin
          chk("stream_pc",    100 + c, instr_pc, epc);
          chk("stream_instr", 100 + c, instr, epc ^ A);
          epc = epc + 32'h4;
          n++;
        end
      end
      chk("stream_count", 200, 32'(n), 32'd4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
